// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type and default bit timing.
// Used by uart_tx and the planned uart_rx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 12 MHz clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 104;

endpackage : uart_pkg

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, held at 0 otherwise.
// tick marks the last cycle of each bit period.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign tick = run && (count == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule : uart_baud_counter

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with level-sensitive send request and re-arm on send low.
// tx and busy are registered and change on the same edge as the FSM state.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_uart_send,
  input  logic [7:0] io_uart_data,
  output logic       io_uart_tx,
  output logic       io_uart_tx_busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  uart_state_t state;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        armed;
  logic        tick;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state != IDLE),
    .tick (tick)
  );

  // NOTE: reset is synchronous, so everything including the shift register is cleared only on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      shift           <= '0;
      bit_idx         <= '0;
      armed           <= 1'b1;
      io_uart_tx      <= 1'b1;
      io_uart_tx_busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          io_uart_tx      <= 1'b1;
          io_uart_tx_busy <= 1'b0;
          if (io_uart_send && armed) begin
            state           <= START;
            shift           <= io_uart_data;
            armed           <= 1'b0;
            io_uart_tx      <= 1'b0;
            io_uart_tx_busy <= 1'b1;
          end else if (!io_uart_send) begin
            armed <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state      <= DATA;
            bit_idx    <= '0;
            io_uart_tx <= shift[0];
            shift      <= shift >> 1;
          end
        end
        DATA: begin
          // shift[0] always holds the next bit to put on the line
          if (tick) begin
            if (bit_idx == 3'd7) begin
              state      <= STOP;
              io_uart_tx <= 1'b1;
            end else begin
              bit_idx    <= bit_idx + 3'd1;
              io_uart_tx <= shift[0];
              shift      <= shift >> 1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            state           <= IDLE;
            io_uart_tx      <= 1'b1;
            io_uart_tx_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLKS_PER_BIT=4): directed scenarios plus random
// stimulus, every cycle compared against a frame-position reference model.
module tb_uart_tx;

  localparam int N = 4;
  localparam int FRAME = 10 * N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send;
  logic [7:0] data;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: position inside the current frame (-1 when idle)
  int         m_pos   = -1;
  logic [7:0] m_byte  = '0;
  logic       m_armed = 1'b1;

  int   rises     = 0;
  int   busy_cnt  = 0;
  logic prev_busy = 1'b0;

  uart_tx #(
    .CLKS_PER_BIT(N)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io_uart_send   (send),
    .io_uart_data   (data),
    .io_uart_tx     (tx),
    .io_uart_tx_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic exp_tx();
    int b;
    if (m_pos < 0) return 1'b1;
    b = m_pos / N;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  task automatic model_update(input logic s, input logic [7:0] d, input logic r);
    if (!r) begin
      m_pos   = -1;
      m_armed = 1'b1;
    end else if (m_pos < 0) begin
      if (s && m_armed) begin
        m_pos   = 0;
        m_byte  = d;
        m_armed = 1'b0;
      end else if (!s) begin
        m_armed = 1'b1;
      end
    end else begin
      m_pos++;
      if (m_pos == FRAME) m_pos = -1;
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare on the falling edge.
  task automatic step(input logic s, input logic [7:0] d, input logic r);
    send  = s;
    data  = d;
    rst_n = r;
    @(posedge clk);
    model_update(s, d, r);
    @(negedge clk);
    cyc++;
    check("tx", {31'd0, tx}, {31'd0, exp_tx()});
    check("busy", {31'd0, busy}, {31'd0, m_pos >= 0});
    if (busy === 1'b1) busy_cnt++;
    if (busy === 1'b1 && prev_busy !== 1'b1) rises++;
    prev_busy = busy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    bit seen;
    send  = 1'b0;
    data  = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    idle(2);

    // 0x55 single-cycle pulse: 40 busy cycles
    busy_cnt = 0; rises = 0;
    step(1'b1, 8'h55, 1'b1);
    idle(FRAME + 5);
    check("b55_len", busy_cnt, FRAME);
    check("b55_frames", rises, 1);

    // 0xA3 held 60 cycles: exactly one frame
    busy_cnt = 0; rises = 0;
    for (int i = 0; i < 60; i++) step(1'b1, 8'hA3, 1'b1);
    check("hold_frames", rises, 1);
    check("hold_len", busy_cnt, FRAME);
    idle(3);
    step(1'b1, 8'hA3, 1'b1);
    idle(FRAME + 3);
    check("rearm_frames", rises, 2);

    // Data changed mid-frame has no effect
    step(1'b1, 8'h0F, 1'b1);
    for (int i = 1; i < 10; i++) step(1'b0, 8'h0F, 1'b1);
    for (int i = 10; i < FRAME + 4; i++) step(1'b0, 8'hF0, 1'b1);

    // Reset at cycle 15 aborts, then a new full frame
    busy_cnt = 0;
    step(1'b1, 8'hC6, 1'b1);
    for (int i = 1; i < 15; i++) step(1'b0, 8'hC6, 1'b1);
    step(1'b0, 8'hC6, 1'b0);
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    idle(3);
    busy_cnt = 0;
    step(1'b1, 8'h9B, 1'b1);
    idle(FRAME + 3);
    check("after_rst_len", busy_cnt, FRAME);

    // Send high on the first edge after release starts a frame
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h5A, 1'b1);
    check("release_start", {31'd0, busy}, 32'd1);
    idle(FRAME + 2);

    // IO-block emulation: send cleared 1 cycle after busy falls, re-set 2 cycles later
    rises = 0;
    step(1'b1, 8'h3C, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1'b1, 8'h3C, 1'b1);
      if (busy === 1'b0) seen = 1'b1;
    end
    check("io_wait1", {31'd0, seen}, 32'd1);
    step(1'b1, 8'h3C, 1'b1);
    step(1'b0, 8'h3C, 1'b1);
    step(1'b0, 8'h3C, 1'b1);
    step(1'b1, 8'h41, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step(1'b1, 8'h41, 1'b1);
      if (busy === 1'b0) seen = 1'b1;
    end
    check("io_wait2", {31'd0, seen}, 32'd1);
    check("io_frames", rises, 2);
    idle(4);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic s, r;
      s = ($urandom_range(0, 9) < 4);
      r = ($urandom_range(0, 199) != 0);
      step(s, 8'($urandom), r);
    end
    idle(FRAME + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx
